// File: rtl/multi_accept_merge_arb_if.sv
// Handshake bundle for multi_accept_merge_arb: N request channels merged
// onto one output channel. "slave" is the arbiter side, "master" the
// requester/consumer side.
interface multi_accept_merge_arb_if #(
  parameter int unsigned NumInp    = 4,
  parameter int unsigned DataWidth = 32
);
  localparam int unsigned IdxWidth = (NumInp > 1) ? $clog2(NumInp) : 1;

  logic [NumInp*DataWidth-1:0] inp_data_i;
  logic [NumInp-1:0]           inp_valid_i;
  logic [NumInp-1:0]           inp_ready_o;
  logic [DataWidth-1:0]        oup_data_o;
  logic                        oup_valid_o;
  logic                        oup_ready_i;
  logic [IdxWidth-1:0]         oup_idx_o;
  logic [NumInp-1:0]           oup_mask_o;

  modport slave (
    input  inp_data_i, inp_valid_i, oup_ready_i,
    output inp_ready_o, oup_data_o, oup_valid_o, oup_idx_o, oup_mask_o
  );

  modport master (
    output inp_data_i, inp_valid_i, oup_ready_i,
    input  inp_ready_o, oup_data_o, oup_valid_o, oup_idx_o, oup_mask_o
  );
endinterface

// File: rtl/multi_accept_merge_arb.sv
// Round-robin N:1 arbiter for the I-cache refill path. One winner per output
// transaction; with MULTI_ACCEPT_ARB_MERGE_EN defined, every other valid input
// whose compare field [CmpMsb:CmpLsb] equals the winner's is accepted in the
// same handshake. Without the macro exactly one input is accepted.
// A stalled output locks the winner until it is taken; flush_i clears the
// lock and the round-robin pointer.
module multi_accept_merge_arb #(
  parameter int unsigned NumInp    = 4,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned CmpLsb    = 0,
  parameter int unsigned CmpMsb    = 31
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  multi_accept_merge_arb_if.slave io
);

  localparam int unsigned    IdxW    = (NumInp > 1) ? $clog2(NumInp) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumInp - 1);
  localparam bit             CfgOk   = (NumInp >= 1) && (CmpLsb <= CmpMsb) &&
                                       (CmpMsb < DataWidth);

  if (!CfgOk) begin : g_bad_cfg
    $error("multi_accept_merge_arb: illegal NumInp/CmpLsb/CmpMsb/DataWidth");
  end

  logic [IdxW-1:0]      r_rr;
  logic [IdxW-1:0]      r_idx;
  logic                 r_lock;

  logic [DataWidth-1:0] w_inp_data [NumInp];
  logic                 w_valid;
  logic                 w_hs;
  logic [IdxW-1:0]      w_win;
  logic [IdxW-1:0]      w_hi_sel;
  logic [IdxW-1:0]      w_lo_sel;
  logic                 w_hi_found;
  logic                 w_lo_found;
  logic [NumInp-1:0]    w_match;
  logic [NumInp-1:0]    w_mask;

  // Split the flat payload bus into one word per requester.
  always_comb begin
    for (int unsigned i = 0; i < NumInp; i++) begin
      w_inp_data[i] = io.inp_data_i[i*DataWidth +: DataWidth];
    end
  end

  // Winner select. The wrap-around scan from r_rr is done as two priority
  // searches: first valid at or above r_rr, else first valid overall.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_sel   = '0;
    w_lo_sel   = '0;
    for (int unsigned i = 0; i < NumInp; i++) begin
      if (io.inp_valid_i[i] && !w_lo_found) begin
        w_lo_found = 1'b1;
        w_lo_sel   = IdxW'(i);
      end
      if (io.inp_valid_i[i] && (IdxW'(i) >= r_rr) && !w_hi_found) begin
        w_hi_found = 1'b1;
        w_hi_sel   = IdxW'(i);
      end
    end
    if (r_lock) begin
      w_win = r_idx;
    end else if (w_hi_found) begin
      w_win = w_hi_sel;
    end else if (w_lo_found) begin
      w_win = w_lo_sel;
    end else begin
      w_win = r_rr;
    end
  end

  // Accept mask: inputs taken together with the winner on a handshake.
  always_comb begin
    w_match = '0;
    for (int unsigned i = 0; i < NumInp; i++) begin
`ifdef MULTI_ACCEPT_ARB_MERGE_EN
      w_match[i] = io.inp_valid_i[i] &&
                   (w_inp_data[i][CmpMsb:CmpLsb] == w_inp_data[w_win][CmpMsb:CmpLsb]);
`else
      w_match[i] = (IdxW'(i) == w_win);
`endif
    end
    w_mask = w_valid ? w_match : '0;
  end

  assign w_valid        = |io.inp_valid_i;
  assign w_hs           = w_valid & io.oup_ready_i;
  assign io.oup_valid_o = w_valid;
  assign io.oup_data_o  = w_inp_data[w_win];
  assign io.oup_idx_o   = w_win;
  assign io.oup_mask_o  = w_mask;
  assign io.inp_ready_o = w_hs ? w_mask : '0;

  // Lock, locked index and round-robin pointer; flush beats a handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr   <= '0;
      r_lock <= 1'b0;
      r_idx  <= '0;
    end else begin
      if (w_valid) begin
        r_idx <= w_win;
      end
      if (flush_i) begin
        r_lock <= 1'b0;
        r_rr   <= '0;
      end else begin
        r_lock <= w_valid & ~io.oup_ready_i;
        if (w_hs) begin
          r_rr <= (w_win == LastIdx) ? '0 : w_win + 1'b1;
        end
      end
    end
  end

`ifndef SYNTHESIS
  logic [NumInp-1:0]           r_hold;
  logic [NumInp*DataWidth-1:0] r_hold_data;

  // Track requesters left waiting so their valid/payload stability can be checked.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hold      <= '0;
      r_hold_data <= '0;
    end else begin
      r_hold      <= io.inp_valid_i & ~io.inp_ready_o;
      r_hold_data <= io.inp_data_i;
    end
  end

  for (genvar g = 0; g < NumInp; g++) begin : g_hold_chk
    a_hold_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      r_hold[g] |-> (io.inp_valid_i[g] &&
                     (io.inp_data_i[g*DataWidth +: DataWidth] ==
                      r_hold_data[g*DataWidth +: DataWidth])));
  end
`endif

endmodule

// File: doc/multi_accept_merge_arb.md
Name: multi_accept_merge_arb

Overview:
- Round-robin N:1 arbiter for the instruction-cache refill path. Several requesters for the same line are served by one downstream transaction.
- One winner is picked per output transaction. At the handshake, every other valid input carrying identical compare bits is accepted in the same cycle.
- Sits between per-port L0/L1 miss handlers and the shared refill/AXI request channel.
- Generalises the locking RR arbiter with:
  - a parametrised compare field,
  - a multi-hot accept mask on the output,
  - a flushable RR pointer.

Parameters:
- NumInp, 4, number of requesters; must be ≥1.
- DataWidth, 32, payload width per input.
- CmpLsb, 0, lowest payload bit used for merge comparison.
- CmpMsb, 31, highest payload bit used for merge comparison; CmpLsb ≤ CmpMsb < DataWidth.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous clear of lock and RR state.
- inp_data_i  in  NumInp*DataWidth  payload; input i at bits [i*DataWidth +: DataWidth].
- inp_valid_i  in  NumInp  per-input valid.
- inp_ready_o  out  NumInp  per-input accept; multi-hot when merged.
- oup_data_o  out  DataWidth  payload of the winner.
- oup_valid_o  out  1  output valid.
- oup_ready_i  in  1  output ready.
- oup_idx_o  out  max(1,$clog2(NumInp))  winner index.
- oup_mask_o  out  NumInp  inputs accepted if handshake occurs this cycle.

Behaviour:
- One clock and asynchronous active-low reset, as fixed: clk_i, and rst_ni asynchronous and active-low.
- State:
  - rr_q: next-priority index.
  - lock_q: stall lock.
  - idx_q: locked winner.
- Reset values: rr_q=0, lock_q=0, idx_q=0.
- All outputs are combinational from inputs and state (zero latency). With inp_valid_i=0: oup_valid_o=0, inp_ready_o=0, oup_mask_o=0, oup_idx_o=rr_q.
- Unlocked selection:
  - Winner w is the first i with inp_valid_i[i]=1, scanning rr_q, rr_q+1, … with wrap modulo NumInp.
  - oup_valid_o = |inp_valid_i.
  - oup_data_o = inp_data_i[w]; oup_idx_o = w.
- Locked (lock_q=1): w = idx_q regardless of other requests.
  - Protocol rule: a requester whose valid is high may not drop valid or change data until its inp_ready_o is seen. Checked by assertion.
- Merge mask:
  - m[i] = inp_valid_i[i] & (inp_data_i[i][CmpMsb:CmpLsb] == inp_data_i[w][CmpMsb:CmpLsb]). m[w] is always 1 when valid.
  - oup_mask_o = oup_valid_o ? m : 0.
  - The mask is evaluated live. It may gain bits during a stall, but bit w never drops.
- Accept: inp_ready_o = (oup_valid_o & oup_ready_i) ? oup_mask_o : 0.
- Lock update (not flushing):
  - lock_d = oup_valid_o & ~oup_ready_i.
  - idx_q <= w whenever oup_valid_o.
- RR update on handshake: rr_q <= (w == NumInp-1) ? 0 : w+1.
  - The pointer advances past the winner only, not past merged inputs.
  - No advance without a handshake.
- flush_i=1 at a clock edge:
  - lock_q <= 0 and rr_q <= 0; flush has priority over a handshake in the same cycle.
  - Combinational outputs in the flush cycle still follow the rules above, so a handshake in that cycle is honoured.
- NumInp=1: rr_q is constant 0, oup_idx_o=0, and the mask is inp_valid_i.
- Reset asserted mid-stall: the lock is dropped immediately. The next selection starts from index 0.

Optional Feature:
- MULTI_ACCEPT_ARB_MERGE_EN.
- Defined: merging exactly as described in Behaviour.
- Undefined: m = onehot(w) & {NumInp{oup_valid_o}}. Exactly one input is accepted per handshake, and the compare logic is not instantiated. The CmpLsb/CmpMsb parameters are ignored.

Test Plan:
- Basic round robin: NumInp=4, all valid with distinct data, oup_ready_i=1 for 4 cycles. oup_idx_o sequence is 0,1,2,3, each inp_ready_o one-hot, rr_q wraps to 0.
- Merge: inp_data = {0x40,0x80,0x40,0x40} on inputs 0..3, all valid, rr_q=1, ready=1.
  - MERGE_EN defined: cycle 1 w=1, mask=0b0010; cycle 2 w=2, mask=0b1101, inp_ready_o=0b1101; rr_q=3.
  - MERGE_EN undefined: mask=0b0100 in cycle 2.
- Stall lock: input 2 valid, ready low 3 cycles, input 0 asserts valid in cycle 2 (data differs). oup_idx_o stays 2 through the stall; on ready, inp_ready_o=0b0100; the next winner is 0.
- Mask growth under stall (MERGE_EN): input 1 valid data 0x100, ready low. Input 3 raises valid with data 0x100. oup_mask_o goes 0b0010 → 0b1010; on handshake inp_ready_o=0b1010.
- Flush: lock held on idx 3 with rr_q=2, flush_i pulse with ready low. Next cycle lock_q=0, rr_q=0; with inputs 1 and 3 valid, the winner is 1.
- Reset: assert rst_ni low mid-stall, then release. All state is 0 and inp_ready_o=0 while in reset; the first winner after release is the lowest valid index.
